candidate_selector: RTL
=======================

CANDIDATE_SELECTOR -- requirements
Module: candidate_selector

Interface
REQ-001 Parameter MAX_WINDOWS_IN_REFERENCE, default 1024: number of entries in count_bus.
REQ-002 Parameter TOP_K, default 4: number of candidate slots reported.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_candidate_selector  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  begin a scan; sampled only in IDLE.
REQ-006 num_windows  input  32  number of count_bus entries to scan, indices 0..num_windows-1; sampled with start.
REQ-007 min_count  input  32  minimum count a window needs to become a candidate; sampled with start.
REQ-008 count_bus  input  32 x MAX_WINDOWS_IN_REFERENCE  per-window query hit counts from the hash table; upstream holds it stable while busy=1.
REQ-009 busy  output  1  high in SCAN and DONE.
REQ-010 done  output  1  one-cycle pulse when the result is final.
REQ-011 cand_valid  output  TOP_K  per-slot valid flag.
REQ-012 cand_window_id  output  32 x TOP_K  window index per slot; slot 0 is the best.
REQ-013 cand_count  output  32 x TOP_K  count per slot.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-015 IDLE with start=1: latch N = min(num_windows, MAX_WINDOWS_IN_REFERENCE), latch thr = max(min_count, 1), clear all cand_* to 0, set idx=0, and go to SCAN (N>0) or DONE (N=0).
REQ-016 SCAN, each cycle: examine count_bus[idx] and idx++; after idx=N-1 is examined, go to DONE.
REQ-017 DONE: done=1 for exactly that cycle, then go to IDLE.
REQ-018 Latency: with start sampled at edge t, done SHALL be high in the cycle after edge t+N (with N=0, the cycle after edge t).
REQ-019 Admission rule: an entry is admitted only when count >= thr, so zero counts are never candidates.
REQ-020 List order: the list stays sorted by count, descending.
REQ-021 Insertion: an admitted entry is placed after all valid slots with count >= its count; lower slots shift down one and the entry in slot TOP_K-1 is dropped.
REQ-022 Insertion when full: if all slots are valid and the entry's count <= cand_count[TOP_K-1], the list is unchanged.
REQ-023 Tie rule: on equal counts, the lower window index ranks higher, because scan order is ascending.
REQ-024 Valid slots: valid slots SHALL always be contiguous from slot 0.
REQ-025 Output hold: cand_* SHALL hold their values from DONE until the next accepted start.
REQ-026 Output changes: cand_* change only on an accepted start (clear) and during SCAN cycles.
REQ-027 start while busy=1 SHALL be ignored, with no effect on state, N, thr or the list.
REQ-028 num_windows, min_count and count_bus changes while busy SHALL NOT affect the latched N or thr.
REQ-029 Only one insertion per cycle; the insert and shift SHALL be resolved in a single cycle with no pipeline bubble.
REQ-030 Width rules: all count comparisons SHALL be unsigned 32-bit; idx width SHALL be clog2(MAX_WINDOWS_IN_REFERENCE)+1 so that idx=N does not wrap.

Reset
REQ-031 reset_candidate_selector=1 at a clock edge SHALL force IDLE with busy=0, done=0, cand_valid=0, cand_window_id=0, cand_count=0 and idx=0.
REQ-032 Reset SHALL take priority over start and over any in-progress SCAN or DONE; an aborted scan produces no done pulse.
REQ-033 start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-034 Ranking scan: counts [0,5,3,5,9,1,7,2], N=8, min_count=2 -> done 9 cycles after start; ids {4,6,1,3}, counts {9,7,5,5}, valid=4'b1111.
REQ-035 Sparse hits: N=6, only count_bus[2]=4 nonzero, min_count=0 -> valid=4'b0001, id0=2, cnt0=4; slots 1-3 read 0.
REQ-036 Zero-length scan: N=0 -> done in the cycle after the start edge; valid=0; busy high for one cycle only.
REQ-037 Clamping and ignored start: num_windows=5000 -> scan of exactly 1024 cycles; a start pulse mid-scan -> no restart, done timing unchanged.
REQ-038 Reset abort: reset asserted at scan cycle 3 of N=8 -> next cycle all outputs 0, state IDLE, no done pulse; a following start runs a clean scan.
REQ-039 Threshold and full-list ties: all counts=3, min_count=4 -> valid=0; all counts=3, min_count=3, N=8 -> ids {0,1,2,3}.

Source files
------------

// File: rtl/candidate_selector_if.sv
// Bus bundle between the hash-table/controller side and candidate_selector:
// scan request, per-window hit counts, status and the ranked candidate list.
interface candidate_selector_if #(
  parameter int unsigned MAX_WINDOWS_IN_REFERENCE = 1024,
  parameter int unsigned TOP_K                    = 4
);
  localparam int unsigned CW = 32;

  logic                                         start;
  logic [CW-1:0]                                num_windows;
  logic [CW-1:0]                                min_count;
  logic [MAX_WINDOWS_IN_REFERENCE-1:0][CW-1:0]  count_bus;
  logic                                         busy;
  logic                                         done;
  logic [TOP_K-1:0]                             cand_valid;
  logic [TOP_K-1:0][CW-1:0]                     cand_window_id;
  logic [TOP_K-1:0][CW-1:0]                     cand_count;

  // Requesting side: issues scans, owns count_bus, consumes the result.
  modport master (
    output start, num_windows, min_count, count_bus,
    input  busy, done, cand_valid, cand_window_id, cand_count
  );

  // Selector side.
  modport slave (
    input  start, num_windows, min_count, count_bus,
    output busy, done, cand_valid, cand_window_id, cand_count
  );
endinterface

// File: rtl/candidate_selector.sv
// Scans count_bus one window per cycle and keeps the TOP_K highest counts
// (ties resolved toward the lower window index) as a sorted candidate list.
module candidate_selector #(
  parameter int unsigned MAX_WINDOWS_IN_REFERENCE = 1024,
  parameter int unsigned TOP_K                    = 4
) (
  input logic                clk,
  input logic                reset_candidate_selector,
  candidate_selector_if.slave bus
);

  localparam int unsigned CW = 32;
  localparam int unsigned AW = $clog2(MAX_WINDOWS_IN_REFERENCE);
  localparam int unsigned IW = AW + 1;           // holds N itself without wrapping
  localparam int unsigned PW = $clog2(TOP_K + 1); // insertion position 0..TOP_K

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [IW-1:0]            n_q;
  logic [IW-1:0]            idx_q;
  logic [CW-1:0]            thr_q;
  logic [TOP_K-1:0]         valid_q;
  logic [TOP_K-1:0][CW-1:0] id_q;
  logic [TOP_K-1:0][CW-1:0] cnt_q;

  logic                     start_acc_c;
  logic                     last_c;
  logic [IW-1:0]            n_clamp_c;
  logic [CW-1:0]            thr_c;
  logic [CW-1:0]            entry_cnt_c;
  logic [CW-1:0]            entry_id_c;
  logic                     admit_c;
  logic [PW-1:0]            pos_c;
  logic [TOP_K-1:0]         valid_sh_c;
  logic [TOP_K-1:0][CW-1:0] id_sh_c;
  logic [TOP_K-1:0][CW-1:0] cnt_sh_c;
  logic [TOP_K-1:0]         valid_d;
  logic [TOP_K-1:0][CW-1:0] id_d;
  logic [TOP_K-1:0][CW-1:0] cnt_d;

  // Scan request decode: start only counts in IDLE; N clamped, threshold floored at 1.
  always_comb begin
    start_acc_c = (state_q == ST_IDLE) && bus.start;
    n_clamp_c   = (bus.num_windows >= CW'(MAX_WINDOWS_IN_REFERENCE))
                  ? IW'(MAX_WINDOWS_IN_REFERENCE)
                  : IW'(bus.num_windows);
    thr_c       = (bus.min_count == '0) ? CW'(1) : bus.min_count;
    last_c      = (idx_q == (n_q - IW'(1)));
  end

  // State register with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset_candidate_selector) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = (n_clamp_c == '0) ? ST_DONE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (last_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so busy/done line up with that state.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      ST_SCAN: busy_d = 1'b1;
      ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Current entry and its sorted insertion point (after every slot with count >= entry).
  always_comb begin
    entry_cnt_c = bus.count_bus[idx_q[AW-1:0]];
    entry_id_c  = CW'(idx_q);
    admit_c     = (entry_cnt_c >= thr_q);
    pos_c       = '0;
    for (int i = 0; i < int'(TOP_K); i++) begin
      if (valid_q[i] && (cnt_q[i] >= entry_cnt_c)) begin
        pos_c = pos_c + PW'(1);
      end
    end
  end

  // Single-cycle insert: slots above pos keep, pos takes the entry, below shift down one.
  always_comb begin
    valid_sh_c = {valid_q[TOP_K-2:0], 1'b0};
    id_sh_c    = {id_q[TOP_K-2:0], CW'(0)};
    cnt_sh_c   = {cnt_q[TOP_K-2:0], CW'(0)};
    valid_d    = valid_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    if (admit_c && (pos_c < PW'(TOP_K))) begin
      for (int i = 0; i < int'(TOP_K); i++) begin
        if (PW'(i) == pos_c) begin
          valid_d[i] = 1'b1;
          id_d[i]    = entry_id_c;
          cnt_d[i]   = entry_cnt_c;
        end else if (PW'(i) > pos_c) begin
          valid_d[i] = valid_sh_c[i];
          id_d[i]    = id_sh_c[i];
          cnt_d[i]   = cnt_sh_c[i];
        end
      end
    end
  end

  // Scan context and candidate list: cleared on accepted start, updated each SCAN cycle.
  always_ff @(posedge clk) begin
    if (reset_candidate_selector) begin
      n_q     <= '0;
      idx_q   <= '0;
      thr_q   <= '0;
      valid_q <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else if (start_acc_c) begin
      n_q     <= n_clamp_c;
      thr_q   <= thr_c;
      idx_q   <= '0;
      valid_q <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else if (state_q == ST_SCAN) begin
      valid_q <= valid_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_q + IW'(1);
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.cand_valid     = valid_q;
  assign bus.cand_window_id = id_q;
  assign bus.cand_count     = cnt_q;

endmodule
